vedic_div16_8: RTL

//  Sequential unsigned divider, inverse of the 8x8 Vedic multiplier datapath.

---
 rtl/vedic_div16_8.sv | 116 +++++++++++
 1 files changed

// File: rtl/vedic_div16_8.sv
// Sequential restoring radix-2 unsigned divider (DW/VW), one quotient bit per clock.
// Optional quotient-overflow flag q_ovf_o is built when VEDIC_DIV_OVF_EN is defined.
module vedic_div16_8 #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [DW-1:0] quotient_o,
    output logic [VW-1:0] remainder_o,
    output logic          div_by_zero_o
`ifdef VEDIC_DIV_OVF_EN
    ,
    output logic          q_ovf_o
`endif
);

    localparam int unsigned CntW = $clog2(DW);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [VW-1:0]   dsr_q, dsr_d;
    logic [VW-1:0]   prem_q, prem_d;
    // Dividend enters here and is shifted out MSB-first while quotient bits shift in.
    logic [DW-1:0]   quo_q, quo_d;
    logic            dbz_q, dbz_d;

    logic [VW:0]     shifted;
    logic [VW-1:0]   trial;
    logic            ge;

    // prem_q < divisor always holds, so a successful trial fits in VW bits.
    assign shifted = {prem_q, quo_q[DW-1]};
    assign ge      = shifted >= {1'b0, dsr_q};
    assign trial   = shifted[VW-1:0] - dsr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    dsr_d = divisor_i;
                    dbz_d = 1'b0;
                    if (divisor_i == '0) begin
                        quo_d   = '1;
                        prem_d  = dividend_i[VW-1:0];
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        quo_d   = dividend_i;
                        prem_d  = '0;
                        cnt_d   = CntW'(DW - 1);
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                prem_d = ge ? trial : shifted[VW-1:0];
                quo_d  = {quo_q[DW-2:0], ge};
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready_o    = (state_q == StIdle);
    assign res_valid_o   = (state_q == StDone);
    assign quotient_o    = quo_q;
    assign remainder_o   = prem_q;
    assign div_by_zero_o = dbz_q;

`ifdef VEDIC_DIV_OVF_EN
    assign q_ovf_o = (state_q == StDone) && !dbz_q && (|quo_q[DW-1:VW]);
`endif

endmodule
